// File: rtl/coin_pkg.sv
// Shared types and default constants for the coin/credit front end.
// Optional build macro: FREE_PLAY_EN (credits never required or consumed).
package coin_pkg;

  typedef enum logic [1:0] {
    ATTRACT = 2'd0,
    START   = 2'd1,
    PLAY    = 2'd2
  } coin_state_e;

  localparam int unsigned DEBOUNCE_CYC_DEF = 500000;   // 10 ms at 50 MHz
  localparam int unsigned LOCKOUT_CYC_DEF  = 15000000; // coin animation length
  localparam int unsigned MAX_CREDITS_DEF  = 9;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button front end: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on every accepted 0->1 level change.
module btn_debounce
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYC);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive synchronised samples that differ from the accepted
  // level; any sample equal to the accepted level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      press_d  = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser and debounce state registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/coin_credit_ctrl.sv
// Arcade coin/credit front end: debounced coin and start buttons, saturating
// credit count, rate-limited e_piece pulses and the attract/start/play FSM.
// Optional build macro: FREE_PLAY_EN -- start never needs or consumes
// credits; coins are credited and pulse e_piece/coin_reject in any mode.
module coin_credit_ctrl
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned LOCKOUT_CYC  = LOCKOUT_CYC_DEF,
  parameter int unsigned MAX_CREDITS  = MAX_CREDITS_DEF,
  parameter int unsigned CREDIT_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_btn,
  input  logic                start_btn,
  input  logic                mode_arcade,
  input  logic                game_over,
  output logic                e_piece,
  output logic                coin_reject,
  output logic                game_start,
  output logic [CREDIT_W-1:0] credits,
  output logic                playing,
  output coin_state_e         dbg_state_o
);

  localparam int unsigned LOCK_W = cnt_width(LOCKOUT_CYC);

  logic coin_press, start_press;
  logic coin_en, need_credit;

  coin_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [LOCK_W-1:0]   lock_q, lock_d;
  logic                e_piece_q, e_piece_d;
  logic                reject_q, reject_d;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_coin_db (
    .clk_i   (clk),
    .reset_i (reset),
    .btn_i   (coin_btn),
    .press_o (coin_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start_db (
    .clk_i   (clk),
    .reset_i (reset),
    .btn_i   (start_btn),
    .press_o (start_press)
  );

`ifdef FREE_PLAY_EN
  assign coin_en     = 1'b1;
  assign need_credit = 1'b0;
`else
  assign coin_en     = mode_arcade;
  assign need_credit = mode_arcade;
`endif

  // Credit arithmetic and lockout: the coin is applied first, then the
  // START charge, so a coin and a grant in one cycle net to zero.
  always_comb begin
    credits_d = credits_q;
    lock_d    = (lock_q != '0) ? lock_q - 1'b1 : lock_q;
    e_piece_d = 1'b0;
    reject_d  = 1'b0;
    if (coin_press && coin_en) begin
      if (credits_q < CREDIT_W'(MAX_CREDITS)) begin
        credits_d = credits_q + 1'b1;
        if (lock_q == '0) begin
          e_piece_d = 1'b1;
          lock_d    = LOCK_W'(LOCKOUT_CYC - 1);
        end
      end else begin
        reject_d = 1'b1;
      end
    end
    if ((state_q == START) && need_credit && (credits_d != '0)) begin
      credits_d = credits_d - 1'b1;
    end
  end

  // Phase FSM next state; the start check sees the registered credit count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ATTRACT: if (start_press && game_over && (!need_credit || (credits_q != '0)))
                 state_d = START;
      START:   state_d = PLAY;
      PLAY:    if (game_over) state_d = ATTRACT;
      default: state_d = ATTRACT;
    endcase
  end

  // State, credit, lockout and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ATTRACT;
      credits_q <= '0;
      lock_q    <= '0;
      e_piece_q <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      lock_q    <= lock_d;
      e_piece_q <= e_piece_d;
      reject_q  <= reject_d;
    end
  end

  assign e_piece     = e_piece_q;
  assign coin_reject = reject_q;
  assign game_start  = (state_q == START);
  assign playing     = (state_q == PLAY);
  assign credits     = credits_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_coin_credit_ctrl.sv
// Self-checking bench for coin_credit_ctrl with a cycle-level reference
// model built from the button/credit rules (sample histories and counters).
module tb_coin_credit_ctrl;
  import coin_pkg::*;

  localparam int DEB  = 4;
  localparam int LOCK = 20;
  localparam int MAXC = 3;
  localparam int CW   = 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset, coin_btn, start_btn, mode_arcade, game_over;
  logic e_piece, coin_reject, game_start, playing;
  logic [CW-1:0] credits;
  coin_state_e dbg_state;

  always #5 clk = ~clk;

  coin_credit_ctrl #(
    .DEBOUNCE_CYC(DEB), .LOCKOUT_CYC(LOCK), .MAX_CREDITS(MAXC), .CREDIT_W(CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .coin_btn    (coin_btn),
    .start_btn   (start_btn),
    .mode_arcade (mode_arcade),
    .game_over   (game_over),
    .e_piece     (e_piece),
    .coin_reject (coin_reject),
    .game_start  (game_start),
    .credits     (credits),
    .playing     (playing),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Button: raw samples per edge kept in a shift history (bit 0 = newest).
  // A level is accepted once the DEB samples that have crossed the two
  // synchroniser stages all show the opposite of the current level.
  bit [15:0] h_coin, h_start;
  bit lvl_coin, lvl_start;
  bit pr_coin, pr_start;
  int m_credits, m_lock;
  bit m_granting, m_playing, m_epiece, m_reject;

  task automatic model_reset();
    h_coin = '0; h_start = '0;
    lvl_coin = 0; lvl_start = 0;
    pr_coin = 0; pr_start = 0;
    m_credits = 0; m_lock = 0;
    m_granting = 0; m_playing = 0; m_epiece = 0; m_reject = 0;
  endtask

  function automatic bit window_is(input bit [15:0] h, input bit v);
    for (int k = 2; k <= DEB + 1; k++) if (h[k] != v) return 0;
    return 1;
  endfunction

  task automatic model_step(input bit r, input bit c, input bit s, input bit arc, input bit go);
    int cr, nl;
    bit ep, rj, ng, np;
    if (r) begin
      model_reset();
      return;
    end
    ep = 0; rj = 0; cr = m_credits;
    nl = (m_lock > 0) ? m_lock - 1 : 0;
    if (pr_coin && arc) begin
      if (m_credits < MAXC) begin
        cr = cr + 1;
        if (m_lock == 0) begin ep = 1; nl = LOCK - 1; end
      end else rj = 1;
    end
    if (m_granting && arc && cr > 0) cr = cr - 1;
    ng = 0; np = m_playing;
    if (m_granting) np = 1;
    else if (m_playing) begin if (go) np = 0; end
    else if (pr_start && go && (!arc || m_credits > 0)) ng = 1;
    m_credits = cr; m_lock = nl; m_epiece = ep; m_reject = rj;
    m_granting = ng; m_playing = np;
    // button acceptance
    h_coin  = {h_coin[14:0], c};
    h_start = {h_start[14:0], s};
    pr_coin = 0; pr_start = 0;
    if (window_is(h_coin, !lvl_coin)) begin lvl_coin = !lvl_coin; pr_coin = lvl_coin; end
    if (window_is(h_start, !lvl_start)) begin lvl_start = !lvl_start; pr_start = lvl_start; end
  endtask

  // ---------------- driver tasks ----------------
  int ep_cnt = 0, rj_cnt = 0, gs_cnt = 0;

  // One clock: model advances on the edge, outputs compared at the negedge.
  task automatic cycle();
    bit r, c, s, a, g;
    r = reset; c = coin_btn; s = start_btn; a = mode_arcade; g = game_over;
    @(posedge clk);
    model_step(r, c, s, a, g);
    @(negedge clk);
    check_eq("e_piece", e_piece, m_epiece);
    check_eq("coin_reject", coin_reject, m_reject);
    check_eq("game_start", game_start, m_granting);
    check_eq("playing", playing, m_playing);
    check_eq("credits", credits, m_credits);
    ep_cnt += int'(e_piece === 1'b1);
    rj_cnt += int'(coin_reject === 1'b1);
    gs_cnt += int'(game_start === 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_e_piece", e_piece, 0);
    check_eq("rst_coin_reject", coin_reject, 0);
    check_eq("rst_game_start", game_start, 0);
    check_eq("rst_playing", playing, 0);
    check_eq("rst_credits", credits, 0);
    model_reset();
    idle(2);
    reset = 1'b0;
    ep_cnt = 0; rj_cnt = 0; gs_cnt = 0;
  endtask

  task automatic coin_hold(input int n);
    coin_btn = 1'b1; idle(n); coin_btn = 1'b0;
  endtask

  task automatic start_hold(input int n);
    start_btn = 1'b1; idle(n); start_btn = 1'b0;
  endtask

  // Raises coin_btn and returns the number of cycles until e_piece (-1 if none).
  task automatic coin_latency(output int lat);
    lat = -1;
    coin_btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (e_piece === 1'b1 && lat < 0) lat = k;
    end
    coin_btn = 1'b0;
    idle(6);
  endtask

  // Random press with optional leading bounce.
  task automatic rand_press(input bit is_coin);
    int nb;
    nb = $urandom_range(0, 3);
    for (int b = 0; b < nb; b++) begin
      if (is_coin) coin_btn = 1'b1; else start_btn = 1'b1;
      idle($urandom_range(1, 3));
      if (is_coin) coin_btn = 1'b0; else start_btn = 1'b0;
      idle($urandom_range(1, 3));
    end
    if (is_coin) coin_hold($urandom_range(1, 9)); else start_hold($urandom_range(1, 9));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int seen;
    reset = 1'b0; coin_btn = 1'b0; start_btn = 1'b0;
    mode_arcade = 1'b1; game_over = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Clean coin
    coin_latency(lat);
    check_eq("clean_latency", lat, 7);
    check_eq("clean_ep_count", ep_cnt, 1);
    check_eq("clean_credits", credits, 1);
    check_eq("clean_reject", rj_cnt, 0);

    // Bounce: toggle every 2 cycles for 12 cycles, then hold
    do_reset();
    for (int t = 0; t < 3; t++) begin
      coin_hold(2);
      idle(2);
    end
    coin_hold(10);
    idle(8);
    check_eq("bounce_ep_count", ep_cnt, 1);
    check_eq("bounce_credits", credits, 1);

    // Lockout: coins at t=0, 10, 25, then a fourth
    do_reset();
    coin_hold(5); idle(5);
    coin_hold(5); idle(10);
    check_eq("lock_ep_after2", ep_cnt, 1);
    check_eq("lock_credits2", credits, 2);
    coin_hold(5); idle(10);
    check_eq("lock_ep_after3", ep_cnt, 2);
    check_eq("lock_credits3", credits, 3);
    coin_hold(5); idle(10);
    check_eq("sat_reject", rj_cnt, 1);
    check_eq("sat_credits", credits, 3);
    check_eq("sat_ep", ep_cnt, 2);

    // Start gating
    do_reset();
    start_hold(5); idle(10);
    check_eq("gate_no_start", gs_cnt, 0);
    check_eq("gate_not_playing", playing, 0);
    coin_hold(5); idle(10);
    start_btn = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle();
      if (game_start === 1'b1) seen = 1;
    end
    check_eq("gate_start_seen", seen, 1);
    game_over = 1'b0;
    idle(3);
    start_btn = 1'b0;
    check_eq("gate_credits0", credits, 0);
    check_eq("gate_playing", playing, 1);
    idle(10);
    game_over = 1'b1;
    idle(1);
    check_eq("gate_over", playing, 0);
    idle(5);

    // Simultaneous coin + start
    do_reset();
    coin_btn = 1'b1; start_btn = 1'b1; idle(5);
    coin_btn = 1'b0; start_btn = 1'b0; idle(10);
    check_eq("sim0_start", gs_cnt, 0);
    check_eq("sim0_credits", credits, 1);
    coin_btn = 1'b1; start_btn = 1'b1; idle(5);
    coin_btn = 1'b0; start_btn = 1'b0; idle(10);
    check_eq("sim1_start", gs_cnt, 1);
    check_eq("sim1_credits", credits, 1);

    // Reset during lockout with two credits
    do_reset();
    coin_hold(5); idle(5); coin_hold(5); idle(8);
    check_eq("rl_credits2", credits, 2);
    do_reset();
    coin_latency(lat);
    check_eq("rl_latency", lat, 7);

    // Randomised traffic
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 29) == 0) do_reset();
      if ($urandom_range(0, 7) == 0) mode_arcade = ~mode_arcade;
      if ($urandom_range(0, 3) == 0) game_over = ~game_over;
      rand_press($urandom_range(0, 2) != 0);
      idle($urandom_range(0, 25));
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
